// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// default latencies and the control state type.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP   = 3'd6
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE,
    RUN
  } md_state_e;

  // Ops 0..3 produce a deferred HI/LO result; the rest act immediately or not at all.
  function automatic logic is_arith(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO arithmetic: signed/unsigned full-width products and
// quotient/remainder pairs, plus a divide-by-zero flag for the divide ops.
module md_calc
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               signed_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;

  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign signed_div  = (op == MD_DIV);
  assign div_by_zero = (b == '0) && ((op == MD_DIV) || (op == MD_DIVU));

  // Signed divide runs on magnitudes; the most negative dividend maps to
  // itself under negation, which still reads correctly as an unsigned magnitude.
  assign a_mag  = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (signed_div && b[WIDTH-1]) ? -b : b;
  assign b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign uq     = a_mag / b_safe;
  assign ur     = a_mag % b_safe;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_lo = (a[WIDTH-1] ^ b[WIDTH-1]) ? -uq : uq;
        res_hi = a[WIDTH-1] ? -ur : ur;
      end
      MD_DIVU: begin
        res_lo = uq;
        res_hi = ur;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO responder: accepts a one-cycle start, holds busy for a fixed
// latency per op class, then commits the pending result to HI/LO.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  md_state_e        state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pending_hi;
  logic [WIDTH-1:0] pending_lo;
  logic             pending_skip;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_by_zero;

  md_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op          (op),
    .a           (a),
    .b           (b),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      count        <= '0;
      hi           <= '0;
      lo           <= '0;
      pending_hi   <= '0;
      pending_lo   <= '0;
      pending_skip <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_arith(op)) begin
              pending_hi   <= res_hi;
              pending_lo   <= res_lo;
              pending_skip <= div_by_zero;
              count        <= ((op == MD_MULT) || (op == MD_MULTU)) ? CW'(MULT_CYCLES)
                                                                    : CW'(DIV_CYCLES);
              busy         <= 1'b1;
              state        <= RUN;
            end else if (op == MD_MTHI) begin
              hi <= a;
            end else if (op == MD_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            busy  <= 1'b0;
            state <= IDLE;
            // A zero divisor keeps the uniform latency but leaves HI/LO untouched.
            if (!pending_skip) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: timeline-based reference model compared
// every cycle, directed literal cases, then randomized requests.
module tb_md_unit;
  import md_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd7;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  bit          m_pend = 1'b0, m_skip = 1'b0;
  int          cyc = 0, done_at = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Returns {skip, hi, lo} straight from the architectural definitions.
  function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint          sp, sq, sr;
    longint unsigned up;
    ref_result = '0;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        ref_result = {1'b0, sp};
      end
      3'd1: begin
        up = {32'h0, x} * {32'h0, y};
        ref_result = {1'b0, up};
      end
      3'd2: begin
        if (y == 32'h0) ref_result = {1'b1, 64'h0};
        else begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          ref_result = {1'b0, sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (y == 32'h0) ref_result = {1'b1, 64'h0};
        else ref_result = {1'b0, x % y, x / y};
      end
      default: ;
    endcase
  endfunction

  // Edge-indexed timeline: an accepted op at edge k commits at edge k+N.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0; m_lo <= '0; m_pend <= 1'b0; m_skip <= 1'b0;
      cyc <= 0; done_at <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_pend) begin
        if (cyc + 1 == done_at) begin
          m_pend <= 1'b0;
          if (!m_skip) begin
            m_hi <= m_phi;
            m_lo <= m_plo;
          end
        end
      end else if (start) begin
        if (op < 3'd4) begin
          {m_skip, m_phi, m_plo} <= ref_result(op, a, b);
          m_pend  <= 1'b1;
          done_at <= cyc + 1 + ((op < 3'd2) ? 5 : 10);
        end else if (op == 3'd4) m_hi <= a;
        else if (op == 3'd5) m_lo <= a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, m_pend});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // Call between clock edges; drives the strobe at once and counts busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int nb);
    bit done;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1 start = 1'b0; op = 3'd7;
    nb = 0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!done) begin
        @(negedge clk);
        if (!busy) done = 1'b1;
        else nb++;
      end
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!done) begin
        @(negedge clk);
        if (!busy) done = 1'b1;
      end
    end
    check("idle_bound", {31'b0, busy}, 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int nb;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    #2 reset = 1'b1;
    chk_en = 1'b1;

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, nb);
    check("mult_cycles", nb, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    check("model_mult_hi", m_hi, 32'hFFFF_FFFF);
    check("model_mult_lo", m_lo, 32'hFFFF_FFFA);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
    check("multu_cycles", nb, 32'd5);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, nb);
    check("div_cycles", nb, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("model_div_lo", m_lo, 32'hFFFF_FFFD);
    check("model_div_hi", m_hi, 32'hFFFF_FFFF);

    run_op(MD_MTHI, 32'h1234, 32'h0, nb);
    check("mthi_cycles", nb, 32'd0);
    run_op(MD_MTLO, 32'h5678, 32'h0, nb);
    check("mtlo_cycles", nb, 32'd0);
    run_op(MD_DIVU, 32'd100, 32'd0, nb);
    check("dz_cycles", nb, 32'd10);
    check("dz_hi", hi, 32'h1234);
    check("dz_lo", lo, 32'h5678);

    start = 1'b1; op = MD_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
    @(posedge clk); #1 start = 1'b0; op = 3'd7;
    repeat (3) @(negedge clk);
    start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd3;
    @(posedge clk); #1 start = 1'b0; op = 3'd7;
    wait_idle();
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);

    start = 1'b1; op = MD_DIVU; a = 32'd10; b = 32'd3;
    @(posedge clk); #1 start = 1'b0; op = 3'd7;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    run_op(MD_MTLO, 32'd7, 32'd0, nb);
    check("post_rst_cycles", nb, 32'd0);
    check("post_rst_lo", lo, 32'd7);
    check("post_rst_hi", hi, 32'h0);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
    end
    @(posedge clk); #1 start = 1'b0; op = 3'd7;
    wait_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide responder for the pipelined MIPS core.
- The execute stage initiates HI/LO operations (MULT, MULTU, DIV, DIVU, MTHI, MTLO) with a one-cycle start strobe.
- This block accepts the request, holds busy for a fixed latency, then commits the results to the architectural HI/LO registers.
- The core stalls any HI/LO-dependent instruction while start or busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe, valid for one cycle; qualifies op, a, b.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- busy  output  1  operation in flight.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.

Behaviour:
- Reset (reset low, asynchronous):
  - busy=0, hi=0, lo=0, counter=0, pending results cleared.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter>0.
- IDLE + start + op in 0..3:
  - On the same edge, latch the computed results into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy is high for exactly N cycles starting the cycle after the start edge.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0: hi<=pending_hi, lo<=pending_lo, busy falls, return to IDLE.
  - hi/lo are visible in the first cycle busy=0.
- IDLE + start + op=4 or 5:
  - hi<=a (MTHI) or lo<=a (MTLO) on that edge.
  - No busy.
- op 6/7, or start low: no state change.
- start while busy: ignored entirely, including MTHI/MTLO. The core never issues this; the assertion checks it.
- MULT: {hi,lo} = signed a × signed b, full 2·WIDTH product.
- MULTU: {hi,lo} = unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - a=0x80000000, b=0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU with b=0):
  - busy still asserts for DIV_CYCLES, keeping timing uniform.
  - hi/lo retain their previous values.
- Back-to-back: a new start is accepted in the first cycle busy=0. Zero idle gap is legal.

Decomposition:
- Package md_pkg:
  - op encodings (MD_MULT … MD_MTLO, MD_NOP);
  - default cycle counts;
  - state enum {IDLE, RUN}.
- Sub-module md_calc, purely combinational:
  - Inputs: op, a, b.
  - Outputs: res_hi, res_lo, div_by_zero.
  - Isolates the arithmetic; md_unit keeps only the counter, FSM and HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3:
  - busy high for 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2:
  - busy 10 cycles;
  - lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0, issued after MTHI 0x1234 and MTLO 0x5678:
  - busy 10 cycles;
  - then hi=0x1234, lo=0x5678 unchanged.
- DIV 0x80000000 / 0xFFFFFFFF, with a start pulse of MULT injected at busy cycle 3:
  - the injected start is ignored;
  - final lo=0x80000000, hi=0.
- DIVU 10/3 started, reset driven low at busy cycle 4 asynchronously between edges:
  - busy, hi and lo are 0 immediately;
  - after release, MTLO 7 gives lo=7 with busy never asserting.
